// File: rtl/tmr_count_enable.sv
// Timer count-enable generator: converts a prescaler tap or a synchronised TMCI pin edge
// into one-clk-wide count-enable pulses for two independent 8-bit counter channels.
module tmr_count_enable #(
  parameter int unsigned CLK_SELECT_BIT_WIDTH = 3,
  parameter int unsigned PRESCALE_WIDTH       = 13,
  parameter int unsigned SYNC_STAGES          = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            TMCI0,
  input  logic                            TMCI1,
  input  logic [CLK_SELECT_BIT_WIDTH-1:0] clock_select_0,
  input  logic [CLK_SELECT_BIT_WIDTH-1:0] clock_select_1,
  input  logic [1:0]                      edge_select_0,
  input  logic [1:0]                      edge_select_1,
  output logic                            count_en_0,
  output logic                            count_en_1
);

  localparam int unsigned VCNT_W   = $clog2(SYNC_STAGES + 2);
  localparam int unsigned NUM_TAPS = 6;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_NONE = 2'b11
  } edge_mode_e;

  logic [PRESCALE_WIDTH-1:0] prescaler;
  logic [SYNC_STAGES-1:0]    sync_0;
  logic [SYNC_STAGES-1:0]    sync_1;
  logic                      hist_0;
  logic                      hist_1;
  logic [VCNT_W-1:0]         valid_cnt;
  logic                      sync_valid;

  logic [NUM_TAPS-1:0]       tap_hit_c;
  logic [1:0]                rise_c;
  logic [1:0]                fall_c;

  // Qualifying edge for one channel's edge mode.
  function automatic logic edge_hit(input edge_mode_e mode, input logic rise, input logic fall);
    logic hit;
    hit = 1'b0;
    case (mode)
      EDGE_RISE: hit = rise;
      EDGE_FALL: hit = fall;
      EDGE_BOTH: hit = rise | fall;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

  // Count-enable decision for one channel from its source select.
  function automatic logic source_hit(input logic [CLK_SELECT_BIT_WIDTH-1:0] sel,
                                      input edge_mode_e                      mode,
                                      input logic [NUM_TAPS-1:0]             taps,
                                      input logic [1:0]                      rise,
                                      input logic [1:0]                      fall);
    logic hit;
    hit = 1'b0;
    case (sel)
      CLK_SELECT_BIT_WIDTH'(0): hit = taps[0];
      CLK_SELECT_BIT_WIDTH'(1): hit = taps[1];
      CLK_SELECT_BIT_WIDTH'(2): hit = taps[2];
      CLK_SELECT_BIT_WIDTH'(3): hit = taps[3];
      CLK_SELECT_BIT_WIDTH'(4): hit = taps[4];
      CLK_SELECT_BIT_WIDTH'(5): hit = taps[5];
      CLK_SELECT_BIT_WIDTH'(6): hit = edge_hit(mode, rise[0], fall[0]);
      CLK_SELECT_BIT_WIDTH'(7): hit = edge_hit(mode, rise[1], fall[1]);
      default:                  hit = 1'b0;
    endcase
    return hit;
  endfunction

  // Tap hits: low log2(N) prescaler bits all ones.
  always_comb begin
    tap_hit_c    = '0;
    tap_hit_c[0] = prescaler[0];
    tap_hit_c[1] = &prescaler[2:0];
    tap_hit_c[2] = &prescaler[4:0];
    tap_hit_c[3] = &prescaler[5:0];
    tap_hit_c[4] = &prescaler[9:0];
    tap_hit_c[5] = &prescaler[12:0];
  end

  // Edges on the synchronised pins, held off until the chain holds real pin data.
  always_comb begin
    rise_c    = '0;
    fall_c    = '0;
    rise_c[0] = sync_valid &  sync_0[SYNC_STAGES-1] & ~hist_0;
    fall_c[0] = sync_valid & ~sync_0[SYNC_STAGES-1] &  hist_0;
    rise_c[1] = sync_valid &  sync_1[SYNC_STAGES-1] & ~hist_1;
    fall_c[1] = sync_valid & ~sync_1[SYNC_STAGES-1] &  hist_1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      sync_0    <= '0;
      sync_1    <= '0;
      hist_0    <= 1'b0;
      hist_1    <= 1'b0;
      valid_cnt <= '0;
      sync_valid <= 1'b0;
    end else begin
      prescaler <= prescaler + PRESCALE_WIDTH'(1);
      sync_0    <= {sync_0[SYNC_STAGES-2:0], TMCI0};
      sync_1    <= {sync_1[SYNC_STAGES-2:0], TMCI1};
      hist_0    <= sync_0[SYNC_STAGES-1];
      hist_1    <= sync_1[SYNC_STAGES-1];
      if (!sync_valid) begin
        valid_cnt <= valid_cnt + VCNT_W'(1);
        if (valid_cnt == VCNT_W'(SYNC_STAGES)) begin
          sync_valid <= 1'b1;
        end
      end
    end
  end

  // Registered count-enable outputs; one clk after the source hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_en_0 <= 1'b0;
      count_en_1 <= 1'b0;
    end else begin
      count_en_0 <= source_hit(clock_select_0, edge_mode_e'(edge_select_0), tap_hit_c,
                               rise_c, fall_c);
      count_en_1 <= source_hit(clock_select_1, edge_mode_e'(edge_select_1), tap_hit_c,
                               rise_c, fall_c);
    end
  end

endmodule

// File: tb/tb_tmr_count_enable.sv
// Scoreboard bench for tmr_count_enable: expected pulse cycles come from a cycle-indexed
// reference model and are checked by an independent negedge monitor.
module tb_tmr_count_enable;

  localparam int MAXC = 32768;

  logic       clk;
  logic       rst_n;
  logic       tmci0;
  logic       tmci1;
  logic [2:0] sel0;
  logic [2:0] sel1;
  logic [1:0] es0;
  logic [1:0] es1;
  logic       count_en_0;
  logic       count_en_1;

  int checks;
  int errors;
  int cyc;
  bit mon_on;
  bit pin0_h [0:MAXC];
  bit pin1_h [0:MAXC];
  int exp_q0 [$];
  int exp_q1 [$];

  tmr_count_enable dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .TMCI0          (tmci0),
    .TMCI1          (tmci1),
    .clock_select_0 (sel0),
    .clock_select_1 (sel1),
    .edge_select_0  (es0),
    .edge_select_1  (es1),
    .count_en_0     (count_en_0),
    .count_en_1     (count_en_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: edge c counted from reset release (first posedge after release is c=1).
  // Internal /N pulses after edge c when c is a multiple of N; external edge between
  // the pin values sampled at edges c-3 and c-2 shows up after edge c, never before c=4.
  function automatic bit exp_pulse(input int c, input logic [2:0] s, input logic [1:0] e);
    int  n;
    bit  a;
    bit  b;
    bit  r;
    bit  f;
    case (s)
      3'd0: n = 2;
      3'd1: n = 8;
      3'd2: n = 32;
      3'd3: n = 64;
      3'd4: n = 1024;
      3'd5: n = 8192;
      default: n = 0;
    endcase
    if (n != 0) return (c % n) == 0;
    if (c < 4) return 1'b0;
    a = (s == 3'd6) ? pin0_h[c-3] : pin1_h[c-3];
    b = (s == 3'd6) ? pin0_h[c-2] : pin1_h[c-2];
    r = !a && b;
    f = a && !b;
    case (e)
      2'b00:   return r;
      2'b01:   return f;
      2'b10:   return r || f;
      default: return 1'b0;
    endcase
  endfunction

  // Apply current inputs to the next posedge and record the predicted response.
  task automatic step();
    cyc = cyc + 1;
    pin0_h[cyc] = tmci0;
    pin1_h[cyc] = tmci1;
    if (exp_pulse(cyc, sel0, es0)) exp_q0.push_back(cyc);
    if (exp_pulse(cyc, sel1, es1)) exp_q1.push_back(cyc);
    @(negedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic mon_chan(input int ch, input logic en);
    int have;
    int front;
    have  = (ch == 0) ? exp_q0.size() : exp_q1.size();
    front = -1;
    if (have != 0) front = (ch == 0) ? exp_q0[0] : exp_q1[0];
    if (have != 0 && front <= cyc) begin
      if (ch == 0) void'(exp_q0.pop_front());
      else         void'(exp_q1.pop_front());
      checks = checks + 1;
      if (!(en && front == cyc)) begin
        errors = errors + 1;
        $display("FAIL pulse_ch%0d cycle %0d: count_en=%0b, required 1 (expected at %0d)",
                 ch, cyc, en, front);
      end
    end else if (en) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL spurious_ch%0d cycle %0d: count_en=1, required 0", ch, cyc);
    end
  endtask

  // Monitor: pops expected pulses and flags any unexpected ones.
  always @(negedge clk) begin
    if (mon_on) begin
      if (!rst_n) begin
        checks = checks + 1;
        if (count_en_0 !== 1'b0 || count_en_1 !== 1'b0) begin
          errors = errors + 1;
          $display("FAIL in_reset: count_en_0=%b count_en_1=%b, required 0 0",
                   count_en_0, count_en_1);
        end
      end else begin
        mon_chan(0, count_en_0);
        mon_chan(1, count_en_1);
      end
    end
  end

  task automatic release_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    mon_on = 1'b0;
    rst_n  = 1'b0;
    tmci0  = 1'b0;
    tmci1  = 1'b0;
    sel0   = 3'b001;
    sel1   = 3'b101;
    es0    = 2'b00;
    es1    = 2'b00;
    #2;
    mon_on = 1'b1;
    repeat (3) @(posedge clk);
    release_reset();

    // /8 on channel 0 and /8192 across the prescaler wrap on channel 1.
    run(17000);

    // External rising / both / none on TMCI0 toggling every 5 clk.
    sel0 = 3'b110;
    for (int m = 0; m < 3; m++) begin
      es0 = (m == 0) ? 2'b00 : (m == 1) ? 2'b10 : 2'b11;
      for (int i = 0; i < 40; i++) begin
        tmci0 = ((i / 5) % 2) != 0;
        step();
      end
    end
    tmci0 = 1'b0;
    run(5);

    // Random sources, edge modes and pin activity.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(19) == 0) sel0 = 3'($urandom_range(7));
      if ($urandom_range(19) == 0) sel1 = 3'($urandom_range(7));
      if ($urandom_range(29) == 0) es0 = 2'($urandom_range(3));
      if ($urandom_range(29) == 0) es1 = 2'($urandom_range(3));
      if ($urandom_range(3) == 0) tmci0 = ~tmci0;
      if ($urandom_range(3) == 0) tmci1 = ~tmci1;
      step();
    end

    // Source switch onto a stable high pin, then back to an internal /64 tap.
    sel0  = 3'b000;
    es0   = 2'b00;
    tmci0 = 1'b1;
    run(10);
    sel0 = 3'b110;
    run(20);
    sel0 = 3'b011;
    run(130);

    // Both channels on TMCI1 with different edge modes, then reset mid-stream.
    sel0 = 3'b111;
    sel1 = 3'b111;
    es0  = 2'b00;
    es1  = 2'b01;
    for (int i = 0; i < 63; i++) begin
      tmci1 = ((i / 4) % 2) != 0;
      step();
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    #1;
    checks = checks + 1;
    if (count_en_0 !== 1'b0 || count_en_1 !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL async_reset: count_en_0=%b count_en_1=%b, required 0 0",
               count_en_0, count_en_1);
    end

    // Pin high through reset release must not look like a rising edge.
    tmci0 = 1'b1;
    tmci1 = 1'b0;
    sel0  = 3'b110;
    sel1  = 3'b001;
    es0   = 2'b00;
    es1   = 2'b00;
    repeat (2) @(posedge clk);
    release_reset();
    run(30);
    tmci0 = 1'b0;
    run(6);
    tmci0 = 1'b1;
    run(10);

    mon_on = 1'b0;
    checks = checks + 1;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: pending expected pulses ch0=%0d ch1=%0d, required 0 0",
               exp_q0.size(), exp_q1.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
